// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request per three cycles
// (IDLE -> ISSUE -> RESP), drives registered memory strobes during ISSUE and
// returns extended load data or an error flag during RESP.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word accesses
// are rejected with rsp_err instead of being passed to memory unchanged).
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_7D04
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [2:0]  MemSize,
  output logic [31:0] A_Ram,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Captured request attributes needed in RESP
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        err_q, err_d;

  // Registered memory-side outputs
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [2:0]  mem_size_q, mem_size_d;
  logic [31:0] a_ram_q, a_ram_d;
  logic [31:0] wdata_q, wdata_d;

  // Request decode
  logic        accept;
  logic        funct3_bad;
  logic        store_bad;
  logic        bound_bad;
  logic        misalign_err;
  logic        req_err;
  logic [2:0]  size_bytes;
  logic [32:0] end_addr;
  logic [31:0] a_ram_calc;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // Decode legality, access size and memory address of the incoming request
  always_comb begin
    funct3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111);
    store_bad  = req_we && req_funct3[2];

    unique case (req_funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase

    // 33-bit sum so addresses near 2^32 cannot wrap past the bound check
    end_addr  = {1'b0, req_addr} + {30'd0, size_bytes};
    bound_bad = end_addr > {1'b0, ADDR_LIMIT};

`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign_err = 1'b0;
`endif

    req_err = funct3_bad || store_bad || bound_bad || misalign_err;

    // Halfword accesses use a halfword-lane address: word index, 0, half select
    if (req_funct3[1:0] == 2'b01) begin
      a_ram_calc = {req_addr[31:2], 1'b0, req_addr[1]};
    end else begin
      a_ram_calc = req_addr;
    end
  end

  // FSM next state: fixed three-cycle sequence once a request is accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture request and prepare memory outputs on the acceptance edge
  always_comb begin
    we_d       = we_q;
    funct3_d   = funct3_q;
    err_d      = err_q;
    mem_size_d = mem_size_q;
    a_ram_d    = a_ram_q;
    wdata_d    = wdata_q;
    // Strobes are single-cycle: only set by an acceptance, cleared otherwise
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;

    if (accept) begin
      we_d       = req_we;
      funct3_d   = req_funct3;
      err_d      = req_err;
      mem_size_d = {1'b0, req_funct3[1:0]};
      a_ram_d    = a_ram_calc;
      wdata_d    = req_wdata;
      mem_we_d   = req_we && !req_err;
      mem_re_d   = !req_we && !req_err;
    end
  end

  // State and request registers, asynchronously cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      err_q      <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_size_q <= 3'b000;
      a_ram_q    <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      err_q      <= err_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_size_q <= mem_size_d;
      a_ram_q    <= a_ram_d;
      wdata_q    <= wdata_d;
    end
  end

  assign MemWrite  = mem_we_q;
  assign MemRead   = mem_re_q;
  assign MemSize   = mem_size_q;
  assign A_Ram     = a_ram_q;
  assign WriteData = wdata_q;

  // Response: ReadData is valid during RESP; extend it per the captured funct3
  always_comb begin
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = 32'd0;
    if (rsp_valid && !err_q && !we_q) begin
      unique case (funct3_q)
        3'b000:  rsp_rdata = {{24{ReadData[7]}}, ReadData[7:0]};
        3'b100:  rsp_rdata = {24'd0, ReadData[7:0]};
        3'b001:  rsp_rdata = {{16{ReadData[15]}}, ReadData[15:0]};
        3'b101:  rsp_rdata = {16'd0, ReadData[15:0]};
        3'b010:  rsp_rdata = ReadData;
        default: rsp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_7D04, SHALL be the exclusive upper byte-address bound of data memory.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  input  1  SHALL mark a core access request.
REQ-005 req_ready  output  1  SHALL indicate the unit accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  input  3  SHALL be the RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 req_addr  input  32  SHALL be the byte address.
REQ-009 req_wdata  input  32  SHALL be the store data, right-aligned.
REQ-010 rsp_valid  output  1  SHALL pulse for one cycle per completed request.
REQ-011 rsp_rdata  output  32  SHALL carry extended load data, and 0 for stores and errors.
REQ-012 rsp_err  output  1  SHALL flag a failed request, valid with rsp_valid.
REQ-013 MemWrite, MemRead  output  1 each  SHALL be the memory write and read strobes.
REQ-014 MemSize  output  3  SHALL equal {1'b0, funct3[1:0]}.
REQ-015 A_Ram  output  32  SHALL be the memory byte address.
REQ-016 WriteData  output  32  SHALL equal the registered req_wdata, unmodified.
REQ-017 ReadData  input  32  SHALL be the memory read result, valid one cycle after the MemRead cycle.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on req_valid&&req_ready, ISSUE->RESP and RESP->IDLE unconditionally.
REQ-019 req_ready SHALL be 1 only in IDLE; throughput SHALL be one request per 3 cycles.
REQ-020 On acceptance the request fields SHALL be registered; later changes to req_* SHALL have no effect.
REQ-021 In ISSUE, memory outputs SHALL be registered and driven, with exactly one of MemRead/MemWrite high for one cycle on a valid request.
REQ-022 rsp_valid SHALL be high during RESP only, i.e. 2 cycles after the acceptance edge; the response has no backpressure.
REQ-023 For halfword access, A_Ram SHALL be {addr[31:2], 1'b0, addr[1]}; otherwise A_Ram SHALL equal addr.
REQ-024 In RESP, rsp_rdata SHALL be: LB sign-extend ReadData[7:0]; LBU zero-extend [7:0]; LH/LHU sign/zero-extend [15:0]; LW ReadData.
REQ-025 funct3 values 011, 110 and 111, any store with funct3[2]=1, and addr+size>ADDR_LIMIT SHALL give rsp_err=1 with no strobes issued and the same latency.
REQ-026 Misalignment is halfword addr[0]=1 or word addr[1:0]!=0; its handling SHALL follow REQ-030.
REQ-027 Strobes SHALL deassert to 0 in IDLE and RESP.

Reset
REQ-028 Asserting resetn low SHALL immediately force IDLE, with req_ready=1 and all other outputs (including MemSize, A_Ram and WriteData) set to 0.
REQ-029 A reset during ISSUE or RESP SHALL drop the in-flight request with no response, and the write SHALL be suppressed if reset is asserted before its edge.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL issue no strobe and respond with rsp_err=1 and rsp_rdata=0.
REQ-031 Without LSU_MISALIGN_TRAP_EN, a misaligned request SHALL be issued to memory unchanged, with rsp_err=0 and rsp_rdata extended from ReadData.

Verification
REQ-032 SW 0xDEADBEEF @0x100, then LW @0x100 -> MemWrite one cycle with A_Ram=0x100, MemSize=010; the load returns rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-033 After REQ-032: LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE; LH @0x102 with A_Ram=0x101 -> 0xFFFFDEAD; LHU @0x100 -> 0x0000BEEF.
REQ-034 LW @0x102 -> with the macro, rsp_err=1, MemRead never asserted; without it, MemRead asserted, rsp_err=0.
REQ-035 LW @0x7D04, funct3=011, or store with funct3=100 -> rsp_err=1, no strobes, rsp_rdata=0.
REQ-036 resetn low during ISSUE of SW @0x200 -> no rsp_valid, outputs 0, req_ready=1 after release, and a subsequent LW @0x200 returns the pre-existing contents.
REQ-037 req_valid held high continuously -> acceptances exactly 3 cycles apart, with req_ready low in ISSUE and RESP.
